fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Owns the PC (R7), fetches 16-bit instructions and holds each one
//            for the decoder until it advances or R7 is redirected.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] BUBBLE   = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_inc,
    input  logic        pc_wr_en,
    input  logic [15:0] pc_wr_data,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_REQ     = 2'd1;
    localparam logic [1:0]  S_ISSUE   = 2'd2;
    localparam logic [7:0]  C_TIMEOUT = 8'(TIMEOUT);
    localparam logic [15:0] C_PC_MASK = 16'hFFFE;

    logic [1:0]  r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_inst, w_inst_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic        r_err, w_err_nxt;
    logic [15:0] w_step;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_step    = pc_inc ? PC_STEP : 16'd0;

    // Reset wins over everything, including a response arriving on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC & C_PC_MASK;
            r_inst  <= BUBBLE;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                w_inst_nxt  = BUBBLE;
                w_cnt_nxt   = 8'd0;
            end
            S_REQ: begin
                if (imem_valid) begin
                    w_state_nxt = S_ISSUE;
                    w_inst_nxt  = imem_rdata;
                    w_cnt_nxt   = 8'd0;
                end else if (w_cnt_inc == C_TIMEOUT) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_ISSUE: begin
                // A write takes the written value as base; pc_inc still adds a step
                if (pc_wr_en || pc_inc) begin
                    w_state_nxt = S_REQ;
                    w_inst_nxt  = BUBBLE;
                    w_cnt_nxt   = 8'd0;
                    if (pc_wr_en) begin
                        w_pc_nxt = (pc_wr_data + w_step) & C_PC_MASK;
                    end else begin
                        w_pc_nxt = (r_pc + PC_STEP) & C_PC_MASK;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_inst_nxt  = BUBBLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        imem_req   = (r_state == S_REQ);
        inst_valid = (r_state == S_ISSUE);
        imem_addr  = r_pc;
        pc         = r_pc;
        inst       = r_inst;
        fetch_err  = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [15:0] C_BUBBLE = 16'hF000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_inc;
    logic        pc_wr_en;
    logic [15:0] pc_wr_data;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        inst_valid;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          req_cycles = 0;
    logic [15:0] mem_word;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_inc     (pc_inc),
        .pc_wr_en   (pc_wr_en),
        .pc_wr_data (pc_wr_data),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Memory answers after mem_lat request cycles; negative latency never answers
    assign imem_valid = imem_req && (mem_lat >= 0) && (req_cycles >= mem_lat);
    assign imem_rdata = mem_word;

    always @(posedge clk) begin
        if (imem_req && !imem_valid) req_cycles <= req_cycles + 1;
        else                         req_cycles <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] p, input logic [15:0] i, input logic e);
        exp_t x;
        x.pc   = p;
        x.inst = i;
        x.err  = e;
        return x;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every presented instruction or error pulse consumes one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (inst_valid !== 1'b1) chk("bubble_inst", {16'd0, inst}, {16'd0, C_BUBBLE});
            if (inst_valid === 1'b1 || fetch_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {30'd0, inst_valid, fetch_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", {16'd0, pc}, {16'd0, e.pc});
                    chk("sb_err", {31'd0, fetch_err}, {31'd0, e.err});
                    chk("sb_valid", {31'd0, inst_valid}, {31'd0, ~e.err});
                    if (!e.err) chk("sb_inst", {16'd0, inst}, {16'd0, e.inst});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pc_inc = 1'b1; pc_wr_en = 1'b0; pc_wr_data = 16'h0000;
        mem_lat = 0; mem_word = 16'h0A08;
        exp_q.push_back(mk(16'h0000, 16'h0A08, 1'b0));
        exp_q.push_back(mk(16'h0002, 16'h0A08, 1'b0));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h0004, 16'hC282, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {16'd0, pc}, 32'h0);
        chk("rst_inst", {16'd0, inst}, {16'd0, C_BUBBLE});
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch: REQ/ISSUE alternate with a zero-wait memory
        step(1);
        chk("seq_req0", {31'd0, imem_req}, 32'd1);
        chk("seq_addr0", {16'd0, imem_addr}, 32'h0000);
        step(2);
        chk("seq_addr1", {16'd0, imem_addr}, 32'h0002);
        step(2);
        chk("seq_addr2", {16'd0, imem_addr}, 32'h0004);
        mem_word = 16'hC282;
        pc_inc = 1'b0;
        step(1);

        // Decoder hold: instruction and PC stay, no new request
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", {16'd0, pc}, 32'h0004);
        end

        // Redirects, including target-2 convention and odd target
        pc_wr_en = 1'b1; pc_wr_data = 16'h000E; pc_inc = 1'b1;
        step(1);
        chk("redir_pc10", {16'd0, pc}, 32'h0010);
        mem_word = 16'h1111; pc_wr_data = 16'h0020;
        exp_q.push_back(mk(16'h0010, 16'h1111, 1'b0));
        step(2);
        chk("redir_pc22", {16'd0, pc}, 32'h0022);
        chk("redir_req22", {31'd0, imem_req}, 32'd1);
        chk("redir_addr22", {16'd0, imem_addr}, 32'h0022);
        mem_word = 16'h2222; pc_inc = 1'b0;
        exp_q.push_back(mk(16'h0022, 16'h2222, 1'b0));
        step(2);
        chk("redir_pc20", {16'd0, pc}, 32'h0020);
        mem_word = 16'h3333; pc_wr_data = 16'h0031;
        exp_q.push_back(mk(16'h0020, 16'h3333, 1'b0));
        step(2);
        chk("redir_pc30", {16'd0, pc}, 32'h0030);
        mem_word = 16'h4444; pc_wr_data = 16'hFFFC; pc_inc = 1'b1;
        exp_q.push_back(mk(16'h0030, 16'h4444, 1'b0));
        step(2);
        chk("wrap_pcFFFE", {16'd0, pc}, 32'hFFFE);

        // Wrap modulo 2^16
        mem_word = 16'h6666; pc_wr_en = 1'b0;
        exp_q.push_back(mk(16'hFFFE, 16'h6666, 1'b0));
        step(2);
        chk("wrap_pc0", {16'd0, pc}, 32'h0000);
        chk("wrap_addr0", {16'd0, imem_addr}, 32'h0000);

        // Slow memory: response after 3 request cycles
        mem_lat = 3; mem_word = 16'h5A5A; pc_inc = 1'b0;
        exp_q.push_back(mk(16'h0000, 16'h5A5A, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("slow_valid", {31'd0, inst_valid}, 32'd0);
            chk("slow_req", {31'd0, imem_req}, 32'd1);
        end
        step(1);
        chk("slow_inst", {16'd0, inst}, 32'h5A5A);
        chk("slow_ivalid", {31'd0, inst_valid}, 32'd1);

        // Timeout: memory never answers
        mem_lat = -1; pc_inc = 1'b1;
        exp_q.push_back(mk(16'h0002, C_BUBBLE, 1'b1));
        step(1);
        step(14);
        chk("to_req15", {31'd0, imem_req}, 32'd1);
        chk("to_err15", {31'd0, fetch_err}, 32'd0);
        step(1);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_idle_req", {31'd0, imem_req}, 32'd0);
        chk("to_pc", {16'd0, pc}, 32'h0002);
        step(1);
        chk("to_err_clr", {31'd0, fetch_err}, 32'd0);
        chk("to_retry_req", {31'd0, imem_req}, 32'd1);
        chk("to_retry_addr", {16'd0, imem_addr}, 32'h0002);

        // Reset during REQ with a response on the same edge
        mem_lat = 0; mem_word = 16'h7777;
        pc_wr_en = 1'b1; pc_wr_data = 16'h0040; pc_inc = 1'b0;
        exp_q.push_back(mk(16'h0002, 16'h7777, 1'b0));
        step(2);
        chk("mid_pc40", {16'd0, pc}, 32'h0040);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        pc_wr_en = 1'b0; rst_n = 1'b0;
        step(1);
        chk("mid_rst_pc", {16'd0, pc}, 32'h0000);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_inst", {16'd0, inst}, {16'd0, C_BUBBLE});
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1; mem_word = 16'h0A08;
        exp_q.push_back(mk(16'h0000, 16'h0A08, 1'b0));
        step(1);
        chk("mid_req_after", {31'd0, imem_req}, 32'd1);
        chk("mid_addr_after", {16'd0, imem_addr}, 32'h0000);
        step(1);
        @(negedge clk);
        #1;
        chk("sb_leftover", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
